prog_loader: RTL and testbench

Boot-time program loader: the write side of the program memory that the fetch stage reads. It receives a framed byte stream from a host link, assembles little-endian 32-bit words and writes them into program memory through its write port. It holds the core in stall until the image is complete and valid. Sits between the host byte interface and the `prog_mem` write port. Its `core_hold` output drives the fetch-stage stall and the decode flush.

---
 rtl/prog_loader.sv | 170 +++++++++++++++++
 tb/tb_prog_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: parses MAGIC/LEN/payload[/CSUM] frames and writes LE 32-bit words to program memory.
// Latency: WE/done/error registered, visible the cycle after the deciding byte is accepted.
// Backpressure: rx_ready low in DONE/ERR and while restart is high; checksum via LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int         MAX_WORDS = 2048,
    parameter logic [7:0] MAGIC     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        WE,
    output logic [12:0] WA,
    output logic [31:0] WD,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [11:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;
    logic        we_q;
    logic [12:0] wa_q;
    logic [31:0] wd_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accept;
    logic [15:0] n_rx;
    logic        last_word;

    assign accept    = rx_valid & rx_ready;
    assign n_rx      = {rx_data, len_lo_q};
    assign last_word = (({4'd0, word_idx_q} + 16'd1) == len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_IDLE;
        end else if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == MAGIC) state_d = S_LEN_LO;
                end
                S_LEN_LO: state_d = S_LEN_HI;
                S_LEN_HI: begin
                    if (n_rx > MAX_N)       state_d = S_ERR;
                    else if (n_rx == 16'd0) state_d = S_END;
                    else                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (byte_cnt_q == 2'd3 && last_word) state_d = S_END;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rx_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        core_hold = 1'b1;
        case (state_q)
            S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: rx_ready = ~restart;
            S_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
            end
            S_ERR:   error = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

    // Bytes shift in from the top so that after three of them asm_q = {b2, b1, b0}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            word_idx_q <= 12'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            we_q       <= 1'b0;
            wa_q       <= 13'd0;
            wd_q       <= 32'd0;
        end else begin
            we_q <= 1'b0;
            if (restart) begin
                word_idx_q <= 12'd0;
                byte_cnt_q <= 2'd0;
            end else if (accept) begin
                case (state_q)
                    S_LEN_LO: len_lo_q <= rx_data;
                    S_LEN_HI: begin
                        len_q      <= n_rx;
                        word_idx_q <= 12'd0;
                        byte_cnt_q <= 2'd0;
                    end
                    S_DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q       <= 1'b1;
                            wa_q       <= {word_idx_q[10:0], 2'b00};
                            wd_q       <= {rx_data, asm_q};
                            word_idx_q <= word_idx_q + 12'd1;
                        end else begin
                            asm_q <= {rx_data, asm_q[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= 8'd0;
        end else if (restart) begin
            csum_q <= 8'd0;
        end else if (accept && state_q == S_LEN_HI) begin
            csum_q <= 8'd0;
        end else if (accept && state_q == S_DATA) begin
            csum_q <= csum_q ^ rx_data;
        end
    end
`endif

    assign WE = we_q;
    assign WA = wa_q;
    assign WD = wd_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized + directed bench for prog_loader; a byte-offset frame model predicts every output each cycle.
module tb_prog_loader;

    localparam int         MAXW = 2048;
    localparam logic [7:0] MG   = 8'hA5;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        restart = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        WE;
    logic [12:0] WA;
    logic [31:0] WD;
    logic        core_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    prog_loader #(.MAX_WORDS(MAXW), .MAGIC(MG)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .WE(WE), .WA(WA), .WD(WD),
        .core_hold(core_hold), .done(done), .error(error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: status 0 hunting, 1 inside frame, 2 loaded, 3 rejected; m_pos counts bytes after MAGIC.
    int          m_status;
    int          m_pos;
    int          m_n;
    int          m_d;
    logic [7:0]  m_x;
    logic [7:0]  m_w [4];
    logic        m_we;
    logic [12:0] m_wa;
    logic [31:0] m_wd;
    bit          m_acc;

    function automatic bit m_ready();
        return !restart && (m_status < 2);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_status = 0; m_pos = 0; m_n = 0; m_x = 8'd0;
            m_we = 1'b0; m_wa = 13'd0; m_wd = 32'd0;
        end else begin
            m_acc = rx_valid && m_ready();
            m_we  = 1'b0;
            if (restart) begin
                m_status = 0; m_pos = 0; m_x = 8'd0;
            end else if (m_acc) begin
                if (m_status == 0) begin
                    if (rx_data == MG) begin
                        m_status = 1; m_pos = 0; m_x = 8'd0;
                    end
                end else begin
                    if (m_pos == 0) begin
                        m_n = int'(rx_data);
                    end else if (m_pos == 1) begin
                        m_n = m_n + int'(rx_data) * 256;
                        if (m_n > MAXW)          m_status = 3;
                        else if (m_n == 0 && !CS) m_status = 2;
                    end else if (m_pos < 2 + 4 * m_n) begin
                        m_d = m_pos - 2;
                        m_w[m_d % 4] = rx_data;
                        m_x = m_x ^ rx_data;
                        if (m_d % 4 == 3) begin
                            m_we = 1'b1;
                            m_wa = 13'(m_d - 3);
                            m_wd = {m_w[3], m_w[2], m_w[1], m_w[0]};
                            if (m_d == 4 * m_n - 1 && !CS) m_status = 2;
                        end
                    end else begin
                        m_status = (rx_data == m_x) ? 2 : 3;
                    end
                    m_pos++;
                end
            end
        end
    end

    logic [12:0] wlog_wa [$];
    logic [31:0] wlog_wd [$];

    always @(negedge clk) begin
        check("rx_ready", rx_ready, m_ready());
        check("WE", WE, m_we);
        check("done", done, m_status == 2);
        check("error", error, m_status == 3);
        check("core_hold", core_hold, m_status != 2);
        if (m_we || !rst) begin
            check("WA", WA, m_wa);
            check("WD", WD, m_wd);
        end
        if (WE) begin
            wlog_wa.push_back(WA);
            wlog_wd.push_back(WD);
        end
    end

    logic [7:0] payload [$];

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
                return;
            end
        end
        n_assert++;
        n_fail++;
        $display("FAIL send_timeout: byte 0x%0h not accepted, rx_ready=%0b required 1", b, rx_ready);
        rx_valid = 1'b0;
    endtask

    // cut < 0 sends the whole frame, otherwise only the first cut bytes.
    task automatic send_frame(input int n, input bit bad_cs, input int gap_max, input int cut);
        logic [7:0] q [$];
        logic [7:0] x;
        logic [15:0] n16;
        n16 = 16'(n);
        q.push_back(MG);
        q.push_back(n16[7:0]);
        q.push_back(n16[15:8]);
        if (n <= MAXW) begin
            x = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
                q.push_back(payload[i]);
                x = x ^ payload[i];
            end
            if (CS) q.push_back(x ^ {7'd0, bad_cs});
        end
        for (int i = 0; i < q.size() && (cut < 0 || i < cut); i++) begin
            send(q[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic fill_payload(input int n);
        payload.delete();
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic clear_log();
        wlog_wa.delete();
        wlog_wd.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        logic [7:0] b;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_core_hold", core_hold, 1);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_WE", WE, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Noise then a two-word frame
        clear_log();
        send(8'h00);
        send(8'h5A);
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(2, 1'b0, 0, -1);
        check("a_done", done, 1);
        check("a_core_hold", core_hold, 0);
        idle(1);
        check("a_nwrites", wlog_wa.size(), 2);
        check("a_wa0", wlog_wa[0], 13'h000);
        check("a_wd0", wlog_wd[0], 32'h0000_0013);
        check("a_wa1", wlog_wa[1], 13'h004);
        check("a_wd1", wlog_wd[1], 32'h0010_0093);
        pulse_restart();
        check("a_done_cleared", done, 0);
        check("a_hold_back", core_hold, 1);

`ifdef LOADER_CHECKSUM_EN
        // Same frame, corrupted checksum
        clear_log();
        send_frame(2, 1'b1, 0, -1);
        check("b_error", error, 1);
        check("b_core_hold", core_hold, 1);
        check("b_rx_ready", rx_ready, 0);
        check("b_nwrites", wlog_wa.size(), 2);
        pulse_restart();
        check("b_error_cleared", error, 0);
`endif

        // Oversized length
        clear_log();
        send(MG);
        send(8'h01);
        send(8'h08);
        check("c_error", error, 1);
        idle(2);
        check("c_nwrites", wlog_wa.size(), 0);
        pulse_restart();

        // Full-capacity image
        clear_log();
        fill_payload(MAXW);
        send_frame(MAXW, 1'b0, 0, -1);
        check("d_done", done, 1);
        idle(1);
        check("d_nwrites", wlog_wa.size(), MAXW);
        check("d_last_wa", wlog_wa[MAXW-1], 13'h1FFC);
        check("d_last_wd", wlog_wd[MAXW-1],
              {payload[4*MAXW-1], payload[4*MAXW-2], payload[4*MAXW-3], payload[4*MAXW-4]});
        pulse_restart();

        // Empty image
        clear_log();
        send_frame(0, 1'b0, 0, -1);
        check("e_done", done, 1);
        idle(1);
        check("e_nwrites", wlog_wa.size(), 0);
        pulse_restart();

        // Async reset two bytes into a word
        clear_log();
        payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(1, 1'b0, 0, 5);
        #2;
        rst = 1'b0;
        #1;
        check("f_WE", WE, 0);
        check("f_core_hold", core_hold, 1);
        check("f_WA", WA, 13'h000);
        check("f_WD", WD, 32'h0);
        idle(2);
        rst = 1'b1;
        idle(1);
        payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(1, 1'b0, 0, -1);
        idle(1);
        check("f_nwrites", wlog_wa.size(), 1);
        check("f_wa", wlog_wa[0], 13'h000);
        check("f_wd", wlog_wd[0], 32'hDEAD_BEEF);

        // Restart held while a byte is offered
        rx_valid = 1'b1;
        rx_data  = MG;
        restart  = 1'b1;
        @(negedge clk);
        check("g_rx_ready_restart", rx_ready, 0);
        @(posedge clk);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        idle(1);

        // Randomized frames
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == MG) b = 8'h00;
                send(b);
            end
            g = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
                send_frame(MAXW + 1 + $urandom_range(0, 300), 1'b0, g, -1);
            end else begin
                n = $urandom_range(0, 6);
                fill_payload(n);
                if ($urandom_range(0, 4) == 0)
                    send_frame(n, 1'b0, g, $urandom_range(1, 2 + 4 * n));
                else
                    send_frame(n, ($urandom_range(0, 3) == 0), g, -1);
            end
            idle($urandom_range(0, 3));
            pulse_restart();
        end

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
